// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC sequencer / fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_R,
    HOLD,
    HALT
  } fetch_state_t;

  localparam logic        RESP_OKAY        = 1'b0;
  localparam logic        RESP_ERR         = 1'b1;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the IFU read channels, decoder handshake and redirect port.
interface fetch_ctrl_if;
  // Every valid/ready pair transfers on a rising clk edge where both are 1;
  // once raised, valid holds (with its payload stable) until that edge.
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output araddr, arvalid, rready, inst, inst_pc, inst_fault, inst_valid,
    input  arready, rdata, rresp, rvalid, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  araddr, arvalid, rready, inst, inst_pc, inst_fault, inst_valid,
    output arready, rdata, rresp, rvalid, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer: one outstanding instruction read at a time, handed to the
// decoder over valid/ready, with redirects that drain stale fetches.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          INST_W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master fc_if,
  output fetch_state_t state_o
);

  fetch_state_t      state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] redir_pc_q, redir_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [INST_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_fault_q, inst_fault_d;
  logic              drop_q, drop_d;
  logic              ar_fire;
  logic              r_fire;

  assign ar_fire = fc_if.arvalid && fc_if.arready;
  assign r_fire  = fc_if.rvalid && fc_if.rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redir_pc_q   <= '0;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
      inst_fault_q <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    drop_d       = drop_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (fc_if.redirect_valid) pc_d = fc_if.redirect_pc;
      end
      REQ: begin
        // pc must not move while arvalid is up, so the target is parked.
        if (fc_if.redirect_valid) begin
          redir_pc_d = fc_if.redirect_pc;
          drop_d     = 1'b1;
        end
        if (ar_fire) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (fc_if.redirect_valid) begin
          redir_pc_d = fc_if.redirect_pc;
          drop_d     = 1'b1;
        end
        if (r_fire) begin
          if (fc_if.redirect_valid) begin
            pc_d    = fc_if.redirect_pc;
            drop_d  = 1'b0;
            state_d = REQ;
          end else if (drop_q) begin
            pc_d    = redir_pc_q;
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d       = fc_if.rdata;
            inst_fault_d = fc_if.rresp;
            inst_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (fc_if.redirect_valid) begin
          pc_d    = fc_if.redirect_pc;
          state_d = REQ;
        end else if (fc_if.inst_ready) begin
          if (inst_fault_q == RESP_ERR) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_q + PC_STEP;
            state_d = REQ;
          end
        end
      end
      HALT: begin
        if (fc_if.redirect_valid) begin
          pc_d    = fc_if.redirect_pc;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fc_if.araddr     = pc_q;
  assign fc_if.arvalid    = (state_q == REQ);
  assign fc_if.rready     = (state_q == WAIT_R);
  assign fc_if.inst_valid = (state_q == HOLD);
  assign fc_if.inst       = inst_q;
  assign fc_if.inst_pc    = inst_pc_q;
  assign fc_if.inst_fault = inst_fault_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: IFU model, AR-address and delivery scoreboards.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic         clk;
  logic         rst;
  fetch_state_t dut_state;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           n_deliv = 0;
  int           r_delay = 0;
  logic         fault_en = 1'b0;
  logic [31:0]  fault_addr = '0;

  logic [31:0]  ar_q[$];
  logic [64:0]  exp_q[$];
  int           deliv_cyc[$];

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk     (clk),
    .rst     (rst),
    .fc_if   (bus),
    .state_o (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[19:0], 12'h013};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [95:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input fetch_state_t s, input string name);
    int n = 0;
    while (dut_state != s && n < 200) begin
      tick();
      n++;
    end
    if (dut_state != s) fail_now(name, dut_state);
  endtask

  task automatic redir(input logic [31:0] pc, input logic rdy);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    bus.inst_ready     = rdy;
    tick();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
  endtask

  task automatic accept_one();
    wait_state(HOLD, "accept_wait_hold");
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
  endtask

  task automatic push_deliv(input logic f, input logic [31:0] pc);
    exp_q.push_back({f, pc, inst_of(pc)});
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_araddr"},     bus.araddr,     RST_PC);
    chk({p, "_arvalid"},    bus.arvalid,    1'b0);
    chk({p, "_rready"},     bus.rready,     1'b0);
    chk({p, "_inst_valid"}, bus.inst_valid, 1'b0);
    chk({p, "_inst"},       bus.inst,       32'h0);
    chk({p, "_inst_pc"},    bus.inst_pc,    RST_PC);
    chk({p, "_inst_fault"}, bus.inst_fault, 1'b0);
    chk({p, "_state"},      dut_state,      IDLE);
  endtask

  // IFU model: accepts AR immediately, returns R after r_delay cycles.
  initial begin
    logic        ar_fire_s, r_fire_s, pend;
    logic [31:0] ar_addr_s, paddr;
    int          cnt;
    pend = 1'b0; paddr = '0; cnt = 0;
    bus.arready = 1'b1;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 1'b0;
    forever begin
      @(negedge clk);
      ar_fire_s = bus.arvalid && bus.arready;
      r_fire_s  = bus.rvalid && bus.rready;
      ar_addr_s = bus.araddr;
      @(posedge clk);
      #1;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (r_fire_s) pend = 1'b0;
        if (ar_fire_s) begin
          pend  = 1'b1;
          paddr = ar_addr_s;
          cnt   = r_delay;
        end else if (pend && cnt > 0) begin
          cnt--;
        end
      end
      bus.rvalid = pend && (cnt == 0);
      bus.rdata  = pend ? inst_of(paddr) : 32'h0;
      bus.rresp  = pend && fault_en && (paddr == fault_addr);
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.arvalid && bus.arready) begin
        if (ar_q.size() == 0) fail_now("ar_unexpected", bus.araddr);
        else chk("ar_addr", bus.araddr, ar_q.pop_front());
      end
      if (bus.inst_valid && bus.inst_ready) begin
        n_deliv++;
        deliv_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail_now("deliv_unexpected", bus.inst_pc);
        else chk("deliv", {bus.inst_fault, bus.inst_pc, bus.inst}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] h_inst, h_pc;
    int          bad;
    rst = 1'b1;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");

    // basic stream, decoder always ready
    ar_q.push_back(32'h8000_0000); ar_q.push_back(32'h8000_0004);
    ar_q.push_back(32'h8000_0008); ar_q.push_back(32'h8000_000C);
    push_deliv(1'b0, 32'h8000_0000); push_deliv(1'b0, 32'h8000_0004);
    push_deliv(1'b0, 32'h8000_0008);
    tick();
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 100 && n_deliv < 3; i++) tick();
    bus.inst_ready = 1'b0;
    if (deliv_cyc.size() >= 3) begin
      chk("stream_gap1", deliv_cyc[1] - deliv_cyc[0], 3);
      chk("stream_gap2", deliv_cyc[2] - deliv_cyc[1], 3);
    end else begin
      fail_now("stream_count", n_deliv);
    end

    // backpressure in HOLD
    push_deliv(1'b0, 32'h8000_000C);
    ar_q.push_back(32'h8000_0010);
    wait_state(HOLD, "bp_hold");
    @(negedge clk);
    h_inst = bus.inst;
    h_pc   = bus.inst_pc;
    chk("bp_pc", h_pc, 32'h8000_000C);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.inst_valid && bus.inst === h_inst && bus.inst_pc === h_pc && !bus.arvalid)) bad++;
    end
    chk("bp_stable", bad, 0);
    tick();
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    @(negedge clk);
    chk("bp_rel_arvalid", bus.arvalid, 1'b1);
    chk("bp_rel_araddr", bus.araddr, 32'h8000_0010);
    tick();

    // redirect in HOLD with simultaneous accept
    push_deliv(1'b0, 32'h8000_0010);
    ar_q.push_back(32'h8000_0200);
    r_delay = $urandom_range(2, 6);
    wait_state(HOLD, "rh_hold");
    redir(32'h8000_0200, 1'b1);
    @(negedge clk);
    chk("rh_arvalid", bus.arvalid, 1'b1);
    chk("rh_araddr", bus.araddr, 32'h8000_0200);
    chk("rh_inst_valid", bus.inst_valid, 1'b0);
    chk("rh_consumed_once", n_deliv, 5);
    tick();

    // redirect while the read is in flight
    ar_q.push_back(32'h8000_0100);
    push_deliv(1'b0, 32'h8000_0100);
    wait_state(WAIT_R, "rf_wait_r");
    redir(32'h8000_0100, 1'b0);
    r_delay = 0;
    accept_one();

    // fault at 0x80000008 halts fetching
    ar_q.push_back(32'h8000_0104);
    ar_q.push_back(32'h8000_0000); ar_q.push_back(32'h8000_0004);
    ar_q.push_back(32'h8000_0008);
    push_deliv(1'b0, 32'h8000_0000); push_deliv(1'b0, 32'h8000_0004);
    push_deliv(1'b1, 32'h8000_0008);
    fault_en   = 1'b1;
    fault_addr = 32'h8000_0008;
    wait_state(HOLD, "flt_hold104");
    redir(32'h8000_0000, 1'b0);
    accept_one();
    accept_one();
    wait_state(HOLD, "flt_hold8");
    @(negedge clk);
    chk("flt_inst_fault", bus.inst_fault, 1'b1);
    chk("flt_inst_pc", bus.inst_pc, 32'h8000_0008);
    tick();
    accept_one();
    wait_state(HALT, "flt_halt");
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.arvalid || dut_state != HALT) bad++;
    end
    chk("halt_quiet", bad, 0);
    fault_en = 1'b0;
    ar_q.push_back(32'h8000_0000);
    push_deliv(1'b0, 32'h8000_0000);
    ar_q.push_back(32'h8000_0004);
    tick();
    redir(32'h8000_0000, 1'b0);
    accept_one();

    // pc wrap at the top of the address space
    ar_q.push_back(32'hFFFF_FFFC);
    push_deliv(1'b0, 32'hFFFF_FFFC);
    ar_q.push_back(32'h0000_0000);
    wait_state(HOLD, "wrap_hold");
    redir(32'hFFFF_FFFC, 1'b0);
    accept_one();

    // reset in the middle of a read
    ar_q.push_back(32'h8000_0040);
    wait_state(HOLD, "rm_hold");
    r_delay = 5;
    redir(32'h8000_0040, 1'b0);
    wait_state(WAIT_R, "rm_wait_r");
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rm");
    tick();
    tick();
    r_delay = 0;
    ar_q.push_back(RST_PC);
    push_deliv(1'b0, RST_PC);
    ar_q.push_back(32'h8000_0004);
    rst = 1'b0;
    @(negedge clk);
    chk("rm_rel_idle", dut_state, IDLE);
    chk("rm_rel_arvalid0", bus.arvalid, 1'b0);
    @(negedge clk);
    chk("rm_rel_arvalid1", bus.arvalid, 1'b1);
    chk("rm_rel_araddr", bus.araddr, RST_PC);
    tick();
    accept_one();

    repeat (10) tick();
    chk("ar_drained", ar_q.size(), 0);
    chk("deliv_drained", exp_q.size(), 0);
    chk("deliv_total", n_deliv, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
